// File: rtl/prn_code_ctrl.sv
// GPS-style Gold code generator (G1/G2 LFSR pair) with chip counter
// and retard/advance code-phase slewing for tracking loops.
module prn_code_ctrl #(
    parameter int CODE_LEN = 1023,
    parameter int SLEW_W   = 10
) (
    input  logic              clock,
    input  logic              sclr,
    input  logic              start,
    input  logic [9:0]        g2_init,
    input  logic              chip_tick,
    input  logic              slew_req,
    input  logic              slew_dir,
    input  logic [SLEW_W-1:0] slew_chips,
    output logic              code_out,
    output logic [9:0]        chip_cnt,
    output logic              epoch,
    output logic              running,
    output logic              busy,
    output logic              slew_done
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, ADV} state_t;

    localparam logic [9:0] LAST = 10'(CODE_LEN - 1);

    state_t            state_q, state_d;
    logic [9:0]        g1_q, g1_d;
    logic [9:0]        g2_q, g2_d;
    logic [9:0]        g2i_q, g2i_d;
    logic [9:0]        cnt_q, cnt_d;
    logic [SLEW_W-1:0] rem_q, rem_d;
    logic              epoch_q, epoch_d;
    logic              done_q, done_d;

    logic              adv;
    logic [9:0]        g1_sh, g2_sh;

    assign g1_sh = {g1_q[8:0], g1_q[2] ^ g1_q[9]};
    assign g2_sh = {g2_q[8:0], g2_q[1] ^ g2_q[2] ^ g2_q[5]
                              ^ g2_q[7] ^ g2_q[8] ^ g2_q[9]};

    always_comb begin
        state_d = state_q;
        g1_d    = g1_q;
        g2_d    = g2_q;
        g2i_d   = g2i_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        epoch_d = 1'b0;
        done_d  = 1'b0;
        adv     = 1'b0;
        if (start) begin
            state_d = RUN;
            g1_d    = 10'h3FF;
            g2_d    = g2_init;
            g2i_d   = g2_init;
            cnt_d   = '0;
            rem_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: ;
                RUN: begin
                    adv = chip_tick;
                    if (slew_req) begin
                        if (slew_chips == '0) begin
                            done_d = 1'b1;
                        end else begin
                            rem_d   = slew_chips;
                            state_d = slew_dir ? ADV : HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (chip_tick) begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q == SLEW_W'(1)) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end
                    end
                end
                ADV: begin
                    // a tick during ADV is absorbed by not consuming remaining
                    adv = 1'b1;
                    if (!chip_tick) begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q == SLEW_W'(1)) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (adv) begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    g1_d    = 10'h3FF;
                    g2_d    = g2i_q;
                    epoch_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                    g1_d  = g1_sh;
                    g2_d  = g2_sh;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q <= IDLE;
            g1_q    <= 10'h3FF;
            g2_q    <= 10'h3FF;
            g2i_q   <= 10'h3FF;
            cnt_q   <= '0;
            rem_q   <= '0;
            epoch_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            g1_q    <= g1_d;
            g2_q    <= g2_d;
            g2i_q   <= g2i_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            epoch_q <= epoch_d;
            done_q  <= done_d;
        end
    end

    assign code_out  = g1_q[9] ^ g2_q[9];
    assign chip_cnt  = cnt_q;
    assign epoch     = epoch_q;
    assign slew_done = done_q;
    assign running   = (state_q != IDLE);
    assign busy      = (state_q == HOLD) || (state_q == ADV);

endmodule

// File: tb/tb_prn_code_ctrl.sv
// Bench for prn_code_ctrl: directed slew/epoch scenarios plus random
// traffic against a chip-index/code-table reference model.
module tb_prn_code_ctrl;

    logic       clock = 1'b0;
    logic       sclr, start, chip_tick, slew_req, slew_dir;
    logic [9:0] g2_init, slew_chips;
    logic       code_out, epoch, running, busy, slew_done;
    logic [9:0] chip_cnt;

    always #5 clock = ~clock;

    prn_code_ctrl dut (
        .clock(clock), .sclr(sclr), .start(start),
        .g2_init(g2_init), .chip_tick(chip_tick),
        .slew_req(slew_req), .slew_dir(slew_dir),
        .slew_chips(slew_chips), .code_out(code_out),
        .chip_cnt(chip_cnt), .epoch(epoch), .running(running),
        .busy(busy), .slew_done(slew_done)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: mode 0 idle, 1 run, 2 hold, 3 adv; code = table[chip index]
    int  m_mode, m_cnt, m_rem;
    bit  m_epoch, m_done;
    bit  chips [0:1022];

    function automatic void build(logic [9:0] init);
        logic [9:0] a, b;
        a = 10'h3FF;
        b = init;
        for (int k = 0; k < 1023; k++) begin
            chips[k] = a[9] ^ b[9];
            a = {a[8:0], a[2] ^ a[9]};
            b = {b[8:0], b[1] ^ b[2] ^ b[5] ^ b[7] ^ b[8] ^ b[9]};
        end
    endfunction

    function automatic void m_adv();
        m_cnt = (m_cnt + 1) % 1023;
        if (m_cnt == 0) m_epoch = 1;
    endfunction

    function automatic void model_step();
        m_epoch = 0;
        m_done  = 0;
        if (sclr) begin
            m_mode = 0; m_cnt = 0; m_rem = 0;
            build(10'h3FF);
        end else if (start) begin
            build(g2_init);
            m_mode = 1; m_cnt = 0; m_rem = 0;
        end else if (m_mode == 1) begin
            if (chip_tick) m_adv();
            if (slew_req) begin
                if (slew_chips == 0) m_done = 1;
                else begin
                    m_rem  = int'(slew_chips);
                    m_mode = slew_dir ? 3 : 2;
                end
            end
        end else if (m_mode == 2) begin
            if (chip_tick) m_rem--;
            if (m_rem == 0) begin m_mode = 1; m_done = 1; end
        end else if (m_mode == 3) begin
            m_adv();
            if (!chip_tick) m_rem--;
            if (m_rem == 0) begin m_mode = 1; m_done = 1; end
        end
    endfunction

    task automatic cyc();
        @(posedge clock);
        model_step();
        #1;
        check("code_out", code_out, chips[m_cnt]);
        check("chip_cnt", chip_cnt, m_cnt);
        check("epoch", epoch, m_epoch);
        check("running", running, m_mode != 0);
        check("busy", busy, m_mode >= 2);
        check("slew_done", slew_done, m_done);
        sclr = 0; start = 0; chip_tick = 0; slew_req = 0;
    endtask

    task automatic do_start(logic [9:0] init);
        g2_init = init; start = 1; cyc();
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) begin chip_tick = 1; cyc(); end
    endtask

    task automatic slew(bit dir, int n);
        slew_req = 1; slew_dir = dir; slew_chips = 10'(n); cyc();
    endtask

    int ep_n, ep_at, busy_n, done_n, done_at;

    initial begin
        sclr = 1; start = 0; chip_tick = 0; slew_req = 0;
        slew_dir = 0; slew_chips = 0; g2_init = 0;
        cyc();
        check("rst_code", code_out, 0);
        check("rst_run", running, 0);

        // 11 chips of g2_init=3FF are all zero
        do_start(10'h3FF);
        for (int i = 0; i < 11; i++) begin
            check("g3ff_chip0", code_out, 0);
            ticks(1);
        end
        check("g3ff_cnt", chip_cnt, 11);

        // full epoch
        do_start(10'(($urandom_range(1, 1022))));
        ep_n = 0; ep_at = 0;
        for (int i = 1; i <= 1023; i++) begin
            ticks(1);
            if (epoch) begin ep_n++; ep_at = i; end
        end
        check("ep_count", ep_n, 1);
        check("ep_at", ep_at, 1023);
        check("ep_cnt", chip_cnt, 0);
        check("ep_code0", code_out, chips[0]);
        ticks(20);

        // retard 5 at chip 100
        do_start(10'h2A5);
        ticks(100);
        slew(0, 5);
        busy_n = 0; done_n = 0; done_at = 0;
        for (int i = 1; i <= 8; i++) begin
            if (busy) busy_n++;
            ticks(1);
            if (slew_done) begin done_n++; done_at = i; end
        end
        check("ret_cnt", chip_cnt, 103);
        check("ret_busy", busy_n, 5);
        check("ret_done", done_n, 1);
        check("ret_done_at", done_at, 5);

        // advance 4 at chip 1020
        do_start(10'h155);
        ticks(1020);
        slew(1, 4);
        busy_n = 0; ep_n = 0; done_n = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy) busy_n++;
            cyc();
            if (epoch) ep_n++;
            if (slew_done) done_n++;
            if (i == 3) check("adv_cnt4", chip_cnt, 1);
        end
        check("adv_busy", busy_n, 4);
        check("adv_ep", ep_n, 1);
        check("adv_done", done_n, 1);
        check("adv_cnt", chip_cnt, 1);

        // advance 3 with a tick absorbed in the 2nd ADV cycle
        do_start(10'h0F0);
        ticks(10);
        slew(1, 3);
        busy_n = 0;
        for (int i = 1; i <= 6; i++) begin
            if (busy) busy_n++;
            chip_tick = (i == 2);
            cyc();
        end
        check("abs_busy", busy_n, 4);
        check("abs_cnt", chip_cnt, 14);

        // zero-length slew
        slew(1, 0);
        check("zero_done", slew_done, 1);

        // sclr during HOLD
        do_start(10'h1C3);
        ticks(50);
        slew(0, 7);
        ticks(2);
        sclr = 1; chip_tick = 1; slew_req = 1; slew_dir = 0;
        slew_chips = 10'd3;
        cyc();
        check("clr_cnt", chip_cnt, 0);
        check("clr_busy", busy, 0);
        check("clr_run", running, 0);
        for (int i = 0; i < 5; i++) begin
            chip_tick = 1; slew_req = 1;
            cyc();
            check("idle_cnt", chip_cnt, 0);
            check("idle_done", slew_done, 0);
        end

        // random traffic
        do_start(10'($urandom));
        for (int i = 0; i < 4000; i++) begin
            sclr       = ($urandom_range(0, 399) == 0);
            start      = ($urandom_range(0, 79) == 0);
            g2_init    = 10'($urandom);
            chip_tick  = $urandom_range(0, 1) == 1;
            slew_req   = ($urandom_range(0, 11) == 0);
            slew_dir   = $urandom_range(0, 1) == 1;
            slew_chips = 10'($urandom_range(0, 9));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
